// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the button-to-SPI sequencer:
//   - FSM state encoding (IDLE / LAUNCH / WAIT, 2 bits)
//   - default SPI word width
//   - command-word layout: button index in the MSBs, switch payload in the LSBs
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int DEFAULT_DATA_W = 8;

   // FSM encoding kept as plain constants so older tools and netlists
   // that grep for the numeric state values keep working.
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   // Command word: {index, payload}. The caller truncates the result to its
   // word width. Words wider than 32 bits are not supported by this helper.
   function automatic logic [31:0] cmd_word(input logic [31:0] idx,
                                            input logic [31:0] payload,
                                            input int unsigned payload_w);
      return (idx << payload_w) | payload;
   endfunction

endpackage

// File: rtl/btn_spi_sequencer_if.sv
// ---------------------------------------------------------------------------
// btn_spi_sequencer_if
// Handshake bundle between the sequencer and the SPI master core.
//   spi_start    sequencer -> SPI  one-cycle launch pulse
//   spi_tx_data  sequencer -> SPI  command word
//   spi_busy     SPI -> sequencer  SPI master busy level
//   spi_done     SPI -> sequencer  one-cycle transfer-complete pulse
//   spi_rx_data  SPI -> sequencer  received word, valid with spi_done
// Modports: master = sequencer side, slave = SPI core side.
// ---------------------------------------------------------------------------
interface btn_spi_sequencer_if
   import spi_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) ();

   logic              spi_start;
   logic [DATA_W-1:0] spi_tx_data;
   logic              spi_busy;
   logic              spi_done;
   logic [DATA_W-1:0] spi_rx_data;

   modport master (
      output spi_start,
      output spi_tx_data,
      input  spi_busy,
      input  spi_done,
      input  spi_rx_data
   );

   modport slave (
      input  spi_start,
      input  spi_tx_data,
      output spi_busy,
      output spi_done,
      output spi_rx_data
   );

endinterface

// File: rtl/btn_edge_pending.sv
// ---------------------------------------------------------------------------
// btn_edge_pending
// Rising-edge detect on debounced buttons plus a per-button pending flag.
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   btn_db_i   in   debounced button levels (clk domain)
//   clr_i      in   one-hot clear from the arbiter's grant
//   pending_o  out  outstanding-press flags
// A new press arriving on the same edge as its own grant is kept (set wins).
// Repeated presses on a flag that is already set merge into one request.
// ---------------------------------------------------------------------------
module btn_edge_pending #(
   parameter int NUM_BTN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_db_i,
   input  logic [NUM_BTN-1:0] clr_i,
   output logic [NUM_BTN-1:0] pending_o
);

   logic [NUM_BTN-1:0] btn_prev_q;
   logic [NUM_BTN-1:0] pending_q;
   logic [NUM_BTN-1:0] pending_d;
   logic [NUM_BTN-1:0] rise;

   always_comb begin
      rise      = btn_db_i & ~btn_prev_q;
      pending_d = (pending_q & ~clr_i) | rise;
   end

   // btn_prev clears on reset, so a button held through reset release is
   // seen as a press on the first active cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_prev_q <= '0;
         pending_q  <= '0;
      end else begin
         btn_prev_q <= btn_db_i;
         pending_q  <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/btn_spi_sequencer.sv
// ---------------------------------------------------------------------------
// btn_spi_sequencer
// Turns debounced button presses into SPI master transactions. Pending
// presses are arbitrated (lowest index first), one transfer is launched with
// command word {index, sw_data}, and the received word is returned. A timeout
// guard abandons a transfer whose spi_done never arrives.
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   btn_db       in   debounced button levels, active-high
//   sw_data      in   switch payload, sampled at grant
//   spi          if   master side of the SPI handshake bundle
//   rx_data_q    out  last received word, held
//   rx_valid     out  one-cycle pulse when rx_data_q updates
//   active_idx   out  index of the granted / most recently granted button
//   pending      out  outstanding-press flags
//   err_timeout  out  sticky timeout flag (cleared only by reset)
// Legal parameters: NUM_BTN 2..8, DATA_W > IDX_W (and <= 32), TIMEOUT_CYC >= 2.
// ---------------------------------------------------------------------------
module btn_spi_sequencer
   import spi_pkg::*;
#(
   parameter int  NUM_BTN     = 4,
   parameter int  DATA_W      = DEFAULT_DATA_W,
   parameter int  TIMEOUT_CYC = 4096,
   localparam int IDX_W       = $clog2(NUM_BTN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_BTN-1:0]      btn_db,
   input  logic [DATA_W-IDX_W-1:0] sw_data,
   btn_spi_sequencer_if.master     spi,
   output logic [DATA_W-1:0]       rx_data_q,
   output logic                    rx_valid,
   output logic [IDX_W-1:0]        active_idx,
   output logic [NUM_BTN-1:0]      pending,
   output logic                    err_timeout
);

   localparam int PAY_W = DATA_W - IDX_W;
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [1:0]         state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [DATA_W-1:0]  tx_q,     tx_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic [DATA_W-1:0]  rxq_q,    rxq_d;
   logic               rxv_q,    rxv_d;
   logic               err_q,    err_d;

   logic [NUM_BTN-1:0] pend_w;
   logic [NUM_BTN-1:0] clr;
   logic [IDX_W-1:0]   winner;

   btn_edge_pending #(
      .NUM_BTN (NUM_BTN)
   ) u_edge_pending (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_db_i  (btn_db),
      .clr_i     (clr),
      .pending_o (pend_w)
   );

   // Fixed-priority pick: scan from the top so the lowest set index wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pend_w[i]) winner = IDX_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      idx_d   = idx_q;
      rxq_d   = rxq_q;
      rxv_d   = 1'b0;
      err_d   = err_q;
      clr     = '0;
      case (state_q)
         ST_IDLE: begin
            if ((|pend_w) && !spi.spi_busy) begin
               idx_d      = winner;
               clr[winner] = 1'b1;
               tx_d       = DATA_W'(cmd_word(32'(winner), 32'(sw_data), PAY_W));
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Done is tested first so a completion on the last allowed
            // cycle still counts as a successful transfer.
            if (spi.spi_done) begin
               rxq_d   = spi.spi_rx_data;
               rxv_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tx_q    <= '0;
         idx_q   <= '0;
         rxq_q   <= '0;
         rxv_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         idx_q   <= idx_d;
         rxq_q   <= rxq_d;
         rxv_q   <= rxv_d;
         err_q   <= err_d;
      end
   end

   // Start is decoded from the registered state, so it drops on the same
   // edge that reset or the FSM leaves LAUNCH.
   assign spi.spi_start   = (state_q == ST_LAUNCH);
   assign spi.spi_tx_data = tx_q;
   assign rx_data_q       = rxq_q;
   assign rx_valid        = rxv_q;
   assign active_idx      = idx_q;
   assign pending         = pend_w;
   assign err_timeout     = err_q;

endmodule

// File: tb/tb_btn_spi_sequencer.sv
module tb_btn_spi_sequencer;

   localparam int NB = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_db = '0;
   logic [5:0] sw_data = '0;
   logic [7:0] rx_data_q;
   logic       rx_valid;
   logic [1:0] active_idx;
   logic [3:0] pending;
   logic       err_timeout;

   btn_spi_sequencer_if #(.DATA_W(DW)) spi_if ();

   btn_spi_sequencer #(
      .NUM_BTN     (NB),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_db      (btn_db),
      .sw_data     (sw_data),
      .spi         (spi_if.master),
      .rx_data_q   (rx_data_q),
      .rx_valid    (rx_valid),
      .active_idx  (active_idx),
      .pending     (pending),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- behavioural reference model ----------------
   // Transaction view: a set of requested buttons, a "start pulse due" flag,
   // and a count of cycles spent waiting for the SPI master.
   logic [3:0] m_prev = '0, m_pend = '0;
   logic       m_launch = 1'b0, m_wait = 1'b0;
   int         m_waited = 0;
   logic [7:0] m_tx = '0, m_rxq = '0;
   logic [1:0] m_idx = '0;
   logic       m_rxv = 1'b0, m_err = 1'b0;

   always @(posedge clk) begin
      logic [3:0] rise;
      logic [3:0] take;
      int         w;
      if (!rst_n) begin
         m_prev = '0; m_pend = '0; m_launch = 1'b0; m_wait = 1'b0; m_waited = 0;
         m_tx = '0; m_rxq = '0; m_idx = '0; m_rxv = 1'b0; m_err = 1'b0;
      end else begin
         rise   = btn_db & ~m_prev;
         m_prev = btn_db;
         take   = '0;
         m_rxv  = 1'b0;
         if (m_wait) begin
            m_waited++;
            if (spi_if.spi_done) begin
               m_rxq = spi_if.spi_rx_data; m_rxv = 1'b1; m_wait = 1'b0;
            end else if (m_waited == TO) begin
               m_err = 1'b1; m_wait = 1'b0;
            end
         end else if (m_launch) begin
            m_launch = 1'b0; m_wait = 1'b1; m_waited = 0;
         end else if (m_pend != 0 && !spi_if.spi_busy) begin
            take = m_pend & (~m_pend + 4'd1);   // isolate lowest requester
            w = 0;
            for (int i = 0; i < NB; i++) if (take[i]) w = i;
            m_idx    = 2'(w);
            m_tx     = {2'(w), sw_data};
            m_launch = 1'b1;
         end
         m_pend = (m_pend & ~take) | rise;
      end
   end

   always @(negedge clk) begin
      chk("mdl.start",   32'(spi_if.spi_start),   32'(m_launch));
      chk("mdl.tx",      32'(spi_if.spi_tx_data), 32'(m_tx));
      chk("mdl.rxv",     32'(rx_valid),           32'(m_rxv));
      chk("mdl.rxq",     32'(rx_data_q),          32'(m_rxq));
      chk("mdl.idx",     32'(active_idx),         32'(m_idx));
      chk("mdl.pending", 32'(pending),            32'(m_pend));
      chk("mdl.err",     32'(err_timeout),        32'(m_err));
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst_n;
      logic [3:0] btn;
      logic [5:0] sw;
      logic       busy;
      logic       done;
      logic [7:0] rx;
      logic       e_start;
      logic [7:0] e_tx;
      logic       e_rxv;
      logic [7:0] e_rxq;
      logic [1:0] e_idx;
      logic [3:0] e_pend;
      logic       e_err;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int cd;
      spi_if.spi_busy    = 1'b0;
      spi_if.spi_done    = 1'b0;
      spi_if.spi_rx_data = '0;

      //            rst  btn   sw    bsy  done rx   | start tx    rxv  rxq   idx  pend  err
      tbl[0]  = '{1'b0, 4'h0, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 4'h0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 4'h0, 1'b0};
      tbl[2]  = '{1'b1, 4'h0, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 4'h0, 1'b0};
      tbl[3]  = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 4'h2, 1'b0};
      tbl[4]  = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 8'h00, 2'd1, 4'h0, 1'b0};
      tbl[5]  = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 8'h00, 2'd1, 4'h0, 1'b0};
      tbl[6]  = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 8'h00, 2'd1, 4'h0, 1'b0};
      tbl[7]  = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 8'h00, 2'd1, 4'h0, 1'b0};
      tbl[8]  = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 8'h00, 2'd1, 4'h0, 1'b0};
      tbl[9]  = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 8'h00, 2'd1, 4'h0, 1'b0};
      tbl[10] = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b1, 8'hA3, 1'b0, 8'h55, 1'b1, 8'hA3, 2'd1, 4'h0, 1'b0};
      tbl[11] = '{1'b1, 4'h2, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 8'hA3, 2'd1, 4'h0, 1'b0};
      tbl[12] = '{1'b1, 4'h0, 6'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 8'hA3, 2'd1, 4'h0, 1'b0};

      for (int r = 0; r < 13; r++) begin
         rst_n              = tbl[r].rst_n;
         btn_db             = tbl[r].btn;
         sw_data            = tbl[r].sw;
         spi_if.spi_busy    = tbl[r].busy;
         spi_if.spi_done    = tbl[r].done;
         spi_if.spi_rx_data = tbl[r].rx;
         tick();
         chk($sformatf("t%0d.start", r), 32'(spi_if.spi_start),   32'(tbl[r].e_start));
         chk($sformatf("t%0d.tx", r),    32'(spi_if.spi_tx_data), 32'(tbl[r].e_tx));
         chk($sformatf("t%0d.rxv", r),   32'(rx_valid),           32'(tbl[r].e_rxv));
         chk($sformatf("t%0d.rxq", r),   32'(rx_data_q),          32'(tbl[r].e_rxq));
         chk($sformatf("t%0d.idx", r),   32'(active_idx),         32'(tbl[r].e_idx));
         chk($sformatf("t%0d.pend", r),  32'(pending),            32'(tbl[r].e_pend));
         chk($sformatf("t%0d.err", r),   32'(err_timeout),        32'(tbl[r].e_err));
      end

      // ---- simultaneous btn0 + btn2: btn0 first, btn2 right after ----
      sw_data = 6'h2A;
      btn_db = 4'b0101; tick();
      chk("arb.pend_set", 32'(pending), 32'h5);
      tick();
      chk("arb.start0", 32'(spi_if.spi_start), 32'h1);
      chk("arb.tx_hi0", 32'(spi_if.spi_tx_data[7:6]), 32'h0);
      chk("arb.pend0",  32'(pending), 32'h4);
      spi_if.spi_rx_data = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("arb.pend_wait", 32'(pending), 32'h4);
         chk("arb.nostart",   32'(spi_if.spi_start), 32'h0);
      end
      spi_if.spi_done = 1'b1; tick(); spi_if.spi_done = 1'b0;
      chk("arb.rxv",  32'(rx_valid),  32'h1);
      chk("arb.rxq",  32'(rx_data_q), 32'h3C);
      tick();
      chk("arb.start2", 32'(spi_if.spi_start), 32'h1);
      chk("arb.tx_hi2", 32'(spi_if.spi_tx_data[7:6]), 32'h2);
      chk("arb.idx2",   32'(active_idx), 32'h2);
      tick();
      spi_if.spi_rx_data = 8'h5A; spi_if.spi_done = 1'b1; tick(); spi_if.spi_done = 1'b0;
      btn_db = 4'b0000; tick();

      // ---- busy holds off the grant ----
      spi_if.spi_busy = 1'b1; btn_db = 4'b1000; tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("busy.nostart", 32'(spi_if.spi_start), 32'h0);
         chk("busy.pend",    32'(pending), 32'h8);
      end
      spi_if.spi_busy = 1'b0; tick();
      chk("busy.start", 32'(spi_if.spi_start), 32'h1);
      chk("busy.idx",   32'(active_idx), 32'h3);
      tick();
      spi_if.spi_rx_data = 8'h11; spi_if.spi_done = 1'b1; tick(); spi_if.spi_done = 1'b0;
      btn_db = 4'b0000; tick();

      // ---- timeout with no spi_done ----
      btn_db = 4'b0010; tick(); tick();
      chk("to.start", 32'(spi_if.spi_start), 32'h1);
      for (int i = 0; i < TO; i++) begin
         tick();
         chk("to.err_early", 32'(err_timeout), 32'h0);
         chk("to.norxv",     32'(rx_valid), 32'h0);
      end
      tick();
      chk("to.err", 32'(err_timeout), 32'h1);
      chk("to.rxv", 32'(rx_valid), 32'h0);
      btn_db = 4'b0000; tick();
      btn_db = 4'b0100; tick(); tick();
      chk("to.restart", 32'(spi_if.spi_start), 32'h1);
      tick();
      spi_if.spi_rx_data = 8'hC7; spi_if.spi_done = 1'b1; tick(); spi_if.spi_done = 1'b0;
      chk("to.rxv2",   32'(rx_valid), 32'h1);
      chk("to.rxq2",   32'(rx_data_q), 32'hC7);
      chk("to.sticky", 32'(err_timeout), 32'h1);
      btn_db = 4'b0000; tick();

      // ---- reset during WAIT ----
      btn_db = 4'b1001; tick(); tick(); tick(); tick();
      rst_n = 1'b0; btn_db = 4'b0000; tick();
      chk("rst.start", 32'(spi_if.spi_start), 32'h0);
      chk("rst.tx",    32'(spi_if.spi_tx_data), 32'h0);
      chk("rst.rxq",   32'(rx_data_q), 32'h0);
      chk("rst.idx",   32'(active_idx), 32'h0);
      chk("rst.pend",  32'(pending), 32'h0);
      chk("rst.err",   32'(err_timeout), 32'h0);
      rst_n = 1'b1; spi_if.spi_rx_data = 8'hEE; spi_if.spi_done = 1'b1; tick();
      spi_if.spi_done = 1'b0;
      chk("rst.late_rxv", 32'(rx_valid), 32'h0);
      chk("rst.late_rxq", 32'(rx_data_q), 32'h0);
      tick();

      // ---- button held through reset release counts as a press ----
      btn_db = 4'b0010; rst_n = 1'b0; tick();
      rst_n = 1'b1; tick();
      chk("hold.pend", 32'(pending), 32'h2);
      tick();
      chk("hold.start", 32'(spi_if.spi_start), 32'h1);
      tick();
      spi_if.spi_done = 1'b1; tick(); spi_if.spi_done = 1'b0;
      btn_db = 4'b0000; tick();

      // ---- randomized traffic against the reference model ----
      cd = 0;
      for (int c = 0; c < 3000; c++) begin
         spi_if.spi_done = 1'b0;
         if (spi_if.spi_start) cd = $urandom_range(1, 20);
         else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               spi_if.spi_done    = 1'b1;
               spi_if.spi_rx_data = 8'($urandom);
            end
         end
         if ($urandom_range(0, 29) == 0) begin
            spi_if.spi_done    = 1'b1;
            spi_if.spi_rx_data = 8'($urandom);
         end
         if ($urandom_range(0, 5) == 0) btn_db = btn_db ^ 4'(1 << $urandom_range(0, 3));
         sw_data         = 6'($urandom);
         spi_if.spi_busy = ($urandom_range(0, 4) == 0);
         rst_n           = ($urandom_range(0, 299) != 0);
         tick();
      end

      rst_n = 1'b1;
      spi_if.spi_done = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_spi_sequencer.md
Name: btn_spi_sequencer

Overview:
- Turns debounced push-button presses into SPI master transactions.
- Sits between the debounce instances on the board inputs and the SPI master core.
- Per button: captures the press, arbitrates among pending presses, launches one SPI transfer with a command byte built from the button index and switches, then returns the received byte.
- Provides a timeout guard against a stalled SPI master.

Parameters:
- NUM_BTN, 4, number of debounced buttons; legal range 2..8.
- DATA_W, 8, SPI word width; must be > IDX_W.
- TIMEOUT_CYC, 4096, max clk cycles from spi_start to spi_done before abort; >= 2.
- IDX_W (localparam), clog2(NUM_BTN), button index width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- btn_db  in  NUM_BTN  debounced button levels, active-high, already in clk domain
- sw_data  in  DATA_W-IDX_W  switch payload, sampled at grant
- spi_busy  in  1  SPI master busy level
- spi_done  in  1  SPI master one-cycle transfer-complete pulse
- spi_rx_data  in  DATA_W  SPI master received word, valid with spi_done
- spi_start  out  1  one-cycle launch pulse to SPI master
- spi_tx_data  out  DATA_W  command word, held stable from grant until return to IDLE
- rx_data_q  out  DATA_W  last received word, held
- rx_valid  out  1  one-cycle pulse when rx_data_q updates
- active_idx  out  IDX_W  index of the granted or most recently granted button
- pending  out  NUM_BTN  outstanding-press flags
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: all state and outputs sample rst_n at posedge clk only. Every output resets to 0. btn_prev resets to 0, and FSM goes to IDLE.
  - A button already held at reset release counts as a press on the first cycle.
- Reset mid-transfer: aborts immediately. spi_start is 0 from the next edge. pending and err_timeout are cleared. No rx_valid is produced.
- Edge detect: btn_prev <= btn_db each cycle; rise = btn_db & ~btn_prev.
- Pending: pending[i] <= 1 on rise[i]; cleared when button i is granted.
  - Same-cycle grant and rise on the same bit: set wins, so the new press is kept.
  - Repeated rises on an already-pending bit merge into one request.
- Arbitration: fixed priority, lowest index wins. Evaluated only in IDLE.
- FSM, all registered:
  - IDLE: if pending != 0 and spi_busy == 0, grant the winner on this edge.
    - active_idx <= winner; clear its pending bit.
    - spi_tx_data <= {winner, sw_data}.
    - Go to LAUNCH.
    - If spi_busy == 1, stay in IDLE with pending held.
  - LAUNCH: spi_start = 1 for exactly this one cycle. Clear timeout counter. Go to WAIT.
  - WAIT: counter increments each cycle.
    - On spi_done: rx_data_q <= spi_rx_data; rx_valid <= 1 for one cycle; go to IDLE.
    - Else if counter == TIMEOUT_CYC-1: err_timeout <= 1; go to IDLE; no rx_valid.
    - Done and timeout on the same cycle: done wins.
- spi_done outside WAIT is ignored; rx_data_q is unchanged.
- Latency: rise sampled at edge k sets pending at k. Grant happens at edge k+1, and spi_start is high in cycle k+1..k+2.
- Back-to-back: after done returns to IDLE, the next grant can occur on the following edge. Minimum spacing between spi_start pulses is 3 cycles plus the transfer time.
- Counter width: clog2(TIMEOUT_CYC) bits. It never wraps because it is reset in LAUNCH.
- err_timeout stays 1 until reset. Operation continues normally after a timeout.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state encoding (IDLE/LAUNCH/WAIT, 2-bit).
  - Default DATA_W.
  - The command-word layout (index in MSBs, payload in LSBs).
- One natural sub-module: btn_edge_pending (edge detect plus pending set/clear with set-priority). The FSM, arbiter and timeout stay in the top.

Test Plan:
1. Reset hold with btn_db=0 -> all outputs 0. After release, press btn1 with sw_data=6'h15 and spi_busy=0 -> spi_start exactly 1 cycle, 2 cycles after the rise; spi_tx_data=8'h55.
2. Complete transfer: 5 cycles after start, pulse spi_done with spi_rx_data=8'hA3 -> rx_data_q=8'hA3, rx_valid high 1 cycle, FSM back in IDLE, active_idx=1.
3. Simultaneous rises on btn0 and btn2 -> btn0 transferred first, pending=4'b0100 during it. btn2 launches on the first IDLE cycle after done, spi_tx_data[7:6]=2'd2.
4. spi_busy=1 while btn3 pending -> no spi_start while busy. Start occurs 1 cycle after busy drops.
5. Timeout with TIMEOUT_CYC=16 and no spi_done -> err_timeout=1 16 cycles after LAUNCH, no rx_valid. A later press still completes normally and err_timeout stays 1.
6. rst_n low for 1 cycle during WAIT -> next cycle all outputs 0 and pending cleared. A late spi_done produces no rx_valid.
